// File: rtl/sha256_arb_pkg.sv
// Shared types and constants for the SHA-256 core arbiter and its helpers.
package sha256_arb_pkg;

  typedef enum logic [1:0] {
    eIdle   = 2'd0,
    eIssue  = 2'd1,
    eWait   = 2'd2,
    eReturn = 2'd3
  } state_e;

  localparam int SHA256_MSG_W = 256;
  localparam int PERF_CNT_W   = 16;

  // Saturating increment for the optional performance counters.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sha256_rr_pick.sv
// Round-robin pick: first set bit of req_i starting at ptr_i, wrapping N-1 -> 0.
module sha256_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] idx_o,
  output logic            found_o
);

  int cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr_i) + i) % N;
      if (req_i[cand]) begin
        idx_o   = cand[ID_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Round-robin sharing of one SHA-256 core among NUM_REQ requesters, one job in flight.
// Optional perf counters are compiled in with `define SHA256_ARB_PERF_EN.
module sha256_core_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MSG_W   = SHA256_MSG_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [NUM_REQ-1:0]       req_v_i,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_v_o,
  output logic [MSG_W-1:0]         rsp_digest_o,
  input  logic [NUM_REQ-1:0]       rsp_yumi_i,
  output logic                     core_v_o,
  output logic [MSG_W-1:0]         core_msg_o,
  input  logic                     core_ready_i,
  input  logic                     core_v_i,
  input  logic [MSG_W-1:0]         core_digest_i,
  output logic                     core_yumi_o,
  output logic                     busy_o
`ifdef SHA256_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_jobs_o,
  output logic [PERF_CNT_W-1:0]         perf_wait_max_o
`endif
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [MSG_W-1:0] digest_q, digest_d;

  logic [ID_W-1:0]  win_id;
  logic             win_found;

  sha256_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i   (req_v_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_id),
    .found_o (win_found)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    msg_d        = msg_q;
    digest_d     = digest_q;
    req_ready_o  = '0;
    rsp_v_o      = '0;
    rsp_digest_o = '0;
    core_v_o     = 1'b0;
    core_msg_o   = '0;
    core_yumi_o  = 1'b0;

    unique case (state_q)
      eIdle: begin
        // Gated by reset so every output reads 0 while reset is held.
        if (win_found && reset_n_i) begin
          req_ready_o[win_id] = 1'b1;
          msg_d      = req_msg_i[win_id*MSG_W +: MSG_W];
          grant_id_d = win_id;
          rr_ptr_d   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          state_d    = eIssue;
        end
      end
      eIssue: begin
        core_v_o   = 1'b1;
        core_msg_o = msg_q;
        if (core_ready_i) state_d = eWait;
      end
      eWait: begin
        core_yumi_o = core_v_i;
        if (core_v_i) begin
          digest_d = core_digest_i;
          state_d  = eReturn;
        end
      end
      eReturn: begin
        rsp_v_o[grant_id_q] = 1'b1;
        rsp_digest_o        = digest_q;
        if (rsp_yumi_i[grant_id_q]) state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase
  end

  assign busy_o = (state_q != eIdle);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= eIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      msg_q      <= '0;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      msg_q      <= msg_d;
      digest_q   <= digest_d;
    end
  end

`ifdef SHA256_ARB_PERF_EN
  logic [NUM_REQ-1:0][PERF_CNT_W-1:0] perf_jobs_q, perf_jobs_d;
  logic [PERF_CNT_W-1:0]              wait_cnt_q, wait_cnt_d;
  logic [PERF_CNT_W-1:0]              wait_max_q, wait_max_d;
  logic                               accept, rsp_done, wait_done;

  assign accept    = (state_q == eIdle) && win_found && reset_n_i;
  assign rsp_done  = (state_q == eReturn) && rsp_yumi_i[grant_id_q];
  assign wait_done = (state_q == eWait) && core_v_i;

  // Job length includes the cycle in which the digest arrives.
  always_comb begin
    perf_jobs_d = perf_jobs_q;
    wait_cnt_d  = wait_cnt_q;
    wait_max_d  = wait_max_q;
    if (rsp_done) perf_jobs_d[grant_id_q] = sat_inc(perf_jobs_q[grant_id_q]);
    if (accept) begin
      wait_cnt_d = '0;
    end else if (state_q == eIssue || state_q == eWait) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
    end
    if (wait_done && (sat_inc(wait_cnt_q) > wait_max_q)) wait_max_d = sat_inc(wait_cnt_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_jobs_q <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
    end else begin
      perf_jobs_q <= perf_jobs_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
    end
  end

  assign perf_jobs_o     = perf_jobs_q;
  assign perf_wait_max_o = wait_max_q;
`endif

  core_v_outside_wait_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) core_v_i |-> (state_q == eWait)
  );

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a fixed-latency stub core.
module tb_sha256_core_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MSG_W   = 256;
  localparam logic [255:0] PAT = {8{32'hA5A5A5A5}};

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_REQ-1:0]       req_v = '0;
  logic [NUM_REQ*MSG_W-1:0] req_msg = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       rsp_v_o;
  logic [MSG_W-1:0]         rsp_digest_o;
  logic [NUM_REQ-1:0]       rsp_yumi = '0;
  logic                     core_v_o;
  logic [MSG_W-1:0]         core_msg_o;
  logic                     core_ready_i;
  logic                     core_v_i;
  logic [MSG_W-1:0]         core_digest_i;
  logic                     core_yumi_o;
  logic                     busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_core_arbiter #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .req_v_i       (req_v),
    .req_msg_i     (req_msg),
    .req_ready_o   (req_ready_o),
    .rsp_v_o       (rsp_v_o),
    .rsp_digest_o  (rsp_digest_o),
    .rsp_yumi_i    (rsp_yumi),
    .core_v_o      (core_v_o),
    .core_msg_o    (core_msg_o),
    .core_ready_i  (core_ready_i),
    .core_v_i      (core_v_i),
    .core_digest_i (core_digest_i),
    .core_yumi_o   (core_yumi_o),
    .busy_o        (busy_o)
  );

  // Stub core: 66-cycle latency, digest = msg ^ PAT, shares the arbiter's reset.
  logic         stub_ready_en = 1'b1;
  logic         stub_busy;
  int           stub_cnt;
  logic [255:0] stub_msg;

  assign core_ready_i  = stub_ready_en & ~stub_busy;
  assign core_v_i      = stub_busy && (stub_cnt == 0);
  assign core_digest_i = core_v_i ? (stub_msg ^ PAT) : '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_msg  <= '0;
    end else if (!stub_busy) begin
      if (core_v_o && core_ready_i) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 65;
        stub_msg  <= core_msg_o;
      end
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (core_yumi_o) begin
      stub_busy <= 1'b0;
    end
  end

  task automatic set_msg(input int r, input logic [255:0] m);
    req_msg[r*MSG_W +: MSG_W] = m;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req_v    = '0;
    rsp_yumi = '0;
    stub_ready_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (rsp_v_o != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_v   = 4'b1111;
    repeat (2) @(negedge clk); #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready_o); end
    checks++; if (rsp_v_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_v got %b exp 0000", rsp_v_o); end
    checks++; if (core_v_o !== 1'b0) begin errors++; $display("FAIL reset_core_v got %b exp 0", core_v_o); end
    checks++; if (core_msg_o !== '0 || rsp_digest_o !== '0) begin errors++; $display("FAIL reset_data got msg %h dig %h exp 0", core_msg_o, rsp_digest_o); end
    checks++; if (busy_o !== 1'b0 || core_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_busy_yumi got %b%b exp 00", busy_o, core_yumi_o); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d exp 0", dut.rr_ptr_q); end
    req_v = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_single();
    bit ok;
    set_msg(2, 256'h1);
    req_v = 4'b0100; #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready_o); end
    @(negedge clk); #1;
    req_v = '0;
    checks++; if (core_v_o !== 1'b1 || core_msg_o !== 256'h1) begin errors++; $display("FAIL single_issue got v=%b msg=%h exp v=1 msg=1", core_v_o, core_msg_o); end
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL single_rr_ptr got %0d exp 3", dut.rr_ptr_q); end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (core_v_i) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_core_done got timeout exp core_v_i"); end
    checks++; if (core_yumi_o !== 1'b1 || rsp_v_o !== 4'b0000) begin errors++; $display("FAIL single_yumi got yumi=%b rsp_v=%b exp 1 0000", core_yumi_o, rsp_v_o); end
    @(negedge clk); #1;
    checks++; if (rsp_v_o !== 4'b0100) begin errors++; $display("FAIL single_rsp_v got %b exp 0100", rsp_v_o); end
    checks++; if (rsp_digest_o !== (256'h1 ^ PAT)) begin errors++; $display("FAIL single_digest got %h exp %h", rsp_digest_o, 256'h1 ^ PAT); end
    rsp_yumi = 4'b0100;
    @(negedge clk); #1;
    rsp_yumi = '0;
    checks++; if (busy_o !== 1'b0 || rsp_v_o !== 4'b0000) begin errors++; $display("FAIL single_done got busy=%b rsp_v=%b exp 0 0000", busy_o, rsp_v_o); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [255:0] m [NUM_REQ];
    int exp_r;
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      m[r] = {64'(r + 1), 64'h0123_4567_89AB_CDEF, 64'(r * 7 + 3), 64'hFEED_0000 + 64'(r)};
      set_msg(r, m[r]);
    end
    req_v = 4'b1111; #1;
    for (int k = 0; k < 5; k++) begin
      exp_r = k % NUM_REQ;
      checks++; if (req_ready_o !== (4'b0001 << exp_r)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready_o, 4'b0001 << exp_r); end
      wait_rsp(ok);
      checks++; if (!ok || rsp_v_o !== (4'b0001 << exp_r)) begin errors++; $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_v_o, 4'b0001 << exp_r); end
      checks++; if (rsp_digest_o !== (m[exp_r] ^ PAT)) begin errors++; $display("FAIL rr_digest%0d got %h exp %h", k, rsp_digest_o, m[exp_r] ^ PAT); end
      rsp_yumi = rsp_v_o;
      @(negedge clk); #1;
      rsp_yumi = '0;
    end
    req_v = '0;
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL rr_final_ptr got %0d exp 1", dut.rr_ptr_q); end
  endtask

  task automatic test_wrap();
    bit ok;
    set_msg(2, 256'h22);
    req_v = 4'b0100; #1;
    @(negedge clk); #1;
    req_v = '0;
    wait_rsp(ok);
    rsp_yumi = rsp_v_o;
    @(negedge clk); #1;
    rsp_yumi = '0;
    checks++; if (!ok || dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL wrap_setup_ptr got %0d exp 3", dut.rr_ptr_q); end
    set_msg(1, 256'h1111);
    req_v = 4'b0010; #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_grant got %b exp 0010", req_ready_o); end
    @(negedge clk); #1;
    req_v = '0;
    checks++; if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL wrap_ptr got %0d exp 2", dut.rr_ptr_q); end
    wait_rsp(ok);
    checks++; if (!ok || rsp_digest_o !== (256'h1111 ^ PAT)) begin errors++; $display("FAIL wrap_digest got %h exp %h", rsp_digest_o, 256'h1111 ^ PAT); end
    rsp_yumi = rsp_v_o;
    @(negedge clk); #1;
    rsp_yumi = '0;
  endtask

  task automatic test_stall();
    bit ok;
    logic [255:0] mm;
    mm = {4{64'hCAFE_F00D_DEAD_BEEF}};
    stub_ready_en = 1'b0;
    set_msg(0, mm);
    req_v = 4'b0001; #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL stall_grant got %b exp 0001", req_ready_o); end
    @(negedge clk); #1;
    req_v = 4'b1111; #1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (core_v_o !== 1'b1 || core_msg_o !== mm) begin errors++; $display("FAIL stall_hold%0d got v=%b msg=%h", i, core_v_o, core_msg_o); end
      checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d got %b exp 0000", i, req_ready_o); end
      @(negedge clk); #1;
    end
    req_v = '0;
    stub_ready_en = 1'b1;
    wait_rsp(ok);
    checks++; if (!ok || rsp_v_o !== 4'b0001 || rsp_digest_o !== (mm ^ PAT)) begin errors++; $display("FAIL stall_rsp got v=%b dig=%h exp 0001 %h", rsp_v_o, rsp_digest_o, mm ^ PAT); end
    rsp_yumi = rsp_v_o;
    @(negedge clk); #1;
    rsp_yumi = '0;
  endtask

  task automatic test_wrong_yumi();
    bit ok;
    set_msg(1, 256'hABCD);
    req_v = 4'b0010; #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL wy_grant got %b exp 0010", req_ready_o); end
    @(negedge clk); #1;
    req_v = '0;
    wait_rsp(ok);
    checks++; if (!ok || rsp_v_o !== 4'b0010) begin errors++; $display("FAIL wy_rsp got %b exp 0010", rsp_v_o); end
    rsp_yumi = 4'b0001;
    @(negedge clk); #1;
    rsp_yumi = '0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_v_o !== 4'b0010 || busy_o !== 1'b1) begin errors++; $display("FAIL wy_hold%0d got rsp_v=%b busy=%b exp 0010 1", i, rsp_v_o, busy_o); end
      if (i < 4) begin @(negedge clk); #1; end
    end
    rsp_yumi = 4'b0010;
    @(negedge clk); #1;
    rsp_yumi = '0;
    checks++; if (busy_o !== 1'b0 || rsp_v_o !== 4'b0000) begin errors++; $display("FAIL wy_release got busy=%b rsp_v=%b exp 0 0000", busy_o, rsp_v_o); end
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    set_msg(3, 256'h3333);
    req_v = 4'b1000; #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL rmw_grant got %b exp 1000", req_ready_o); end
    @(negedge clk); #1;
    req_v = '0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b1 || core_v_o !== 1'b0) begin errors++; $display("FAIL rmw_in_wait got busy=%b core_v=%b exp 1 0", busy_o, core_v_o); end
    req_v   = 4'b1111;
    reset_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || core_v_o !== 1'b0 || core_yumi_o !== 1'b0) begin errors++; $display("FAIL rmw_async got busy=%b core_v=%b yumi=%b exp 000", busy_o, core_v_o, core_yumi_o); end
    checks++; if (req_ready_o !== 4'b0000 || rsp_v_o !== 4'b0000) begin errors++; $display("FAIL rmw_async_req got ready=%b rsp_v=%b exp 0000 0000", req_ready_o, rsp_v_o); end
    repeat (2) @(negedge clk);
    req_v   = '0;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy_o !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL rmw_after got busy=%b ptr=%0d exp 0 0", busy_o, dut.rr_ptr_q); end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rsp_v_o !== 4'b0000 || core_v_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rmw_no_late_digest got activity exp none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stall();
    test_wrong_yumi();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
